// File: rtl/cfo_nco_if.sv
// -----------------------------------------------------------------------------
// cfo_nco_if
// Bundles the frequency-load / sample-strobe inputs and the cos/sin/phase
// outputs of the CFO numerically controlled oscillator.
//   master : the loop filter / controller side; drives the strobes and
//            frequency word, receives the oscillator outputs
//   slave  : the NCO itself
// Signals:
//   freq_valid_i   load strobe for freq_word_i
//   freq_word_i    signed frequency correction, Q1.(PHASE_WIDTH-1)
//   sample_valid_i one strobe per output sample; advances the phase
//   phase_clr_i    synchronous phase accumulator clear
//   nco_valid_o    one-cycle pulse per produced sample
//   cos_o / sin_o  signed cosine / sine
//   phase_o        phase used for the current output sample
// PHASE_WIDTH and AMP_WIDTH must match the parameters of the attached cfo_nco.
// -----------------------------------------------------------------------------
interface cfo_nco_if #(
   parameter int PHASE_WIDTH = 32,
   parameter int AMP_WIDTH   = 16
);
   logic                          freq_valid_i;
   logic [PHASE_WIDTH-1:0]        freq_word_i;
   logic                          sample_valid_i;
   logic                          phase_clr_i;
   logic                          nco_valid_o;
   logic signed [AMP_WIDTH-1:0]   cos_o;
   logic signed [AMP_WIDTH-1:0]   sin_o;
   logic [PHASE_WIDTH-1:0]        phase_o;

   modport master (
      output freq_valid_i, freq_word_i, sample_valid_i, phase_clr_i,
      input  nco_valid_o, cos_o, sin_o, phase_o
   );

   modport slave (
      input  freq_valid_i, freq_word_i, sample_valid_i, phase_clr_i,
      output nco_valid_o, cos_o, sin_o, phase_o
   );
endinterface

// File: rtl/cfo_nco.sv
// -----------------------------------------------------------------------------
// cfo_nco
// Carrier-frequency-offset NCO. A frequency register feeds a modular phase
// accumulator that advances once per sample strobe; each sample phase is
// turned into a cos/sin pair through a quarter-wave table with a half-step
// offset, so mirrored reads are exact and no magnitude ever hits full scale.
// Three-cycle pipeline: address/mirror register, table read, sign apply.
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset
//   bus  cfo_nco_if.slave (frequency load, sample strobe, phase clear in;
//        nco_valid / cos / sin / phase out)
// -----------------------------------------------------------------------------
module cfo_nco #(
   parameter int                     PHASE_WIDTH    = 32,
   parameter int                     LUT_ADDR_WIDTH = 10,
   parameter int                     AMP_WIDTH      = 16,
   parameter logic [PHASE_WIDTH-1:0] FREQ_OFFSET    = '0
) (
   input logic       clk,
   input logic       rst,
   cfo_nco_if.slave  bus
);
   localparam int  N     = 2 ** LUT_ADDR_WIDTH;
   localparam int  MAG_W = AMP_WIDTH - 1;
   localparam real PI    = 3.14159265358979323846;
   localparam real FULL  = real'((2 ** MAG_W) - 1);

   // Quarter-wave table, sampled at (k + 0.5) so lut[N-1-k] is the exact
   // mirror of lut[k] and lut[N-1] stays below 2^(AMP_WIDTH-1).
   logic [MAG_W-1:0] rom [N];
   for (genvar k = 0; k < N; k++) begin : g_rom
      assign rom[k] = MAG_W'($rtoi(FULL * $sin(PI / 2.0 * (real'(k) + 0.5) / real'(N)) + 0.5));
   end

   // Phase front end
   logic [PHASE_WIDTH-1:0]    freq_reg;
   logic [PHASE_WIDTH-1:0]    acc;
   logic [PHASE_WIDTH-1:0]    p;
   logic [1:0]                q;
   logic [LUT_ADDR_WIDTH-1:0] idx;

   // NOTE: always_comb assigns every output on every path, so no latch is inferred.
   always_comb begin
      p   = bus.phase_clr_i ? '0 : acc;
      q   = p[PHASE_WIDTH-1 -: 2];
      idx = p[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH];
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; here that is what makes a same-cycle frequency
   // load leave the current phase step on the old freq_reg.
   always_ff @(posedge clk) begin
      if (rst) begin
         freq_reg <= FREQ_OFFSET;
         acc      <= '0;
      end else begin
         if (bus.freq_valid_i)
            freq_reg <= bus.freq_word_i + FREQ_OFFSET;
         if (bus.phase_clr_i)
            acc <= bus.sample_valid_i ? freq_reg : '0;
         else if (bus.sample_valid_i)
            acc <= acc + freq_reg;
      end
   end

   // Pipeline datapath
   logic [PHASE_WIDTH-1:0]    s1_phase, s2_phase;
   logic [LUT_ADDR_WIDTH-1:0] s1_sin_addr, s1_cos_addr;
   logic                      s1_sin_neg, s1_cos_neg;
   logic [MAG_W-1:0]          s2_sin_mag, s2_cos_mag;
   logic                      s2_sin_neg, s2_cos_neg;
   logic                      s1_valid, s2_valid, out_valid;
   logic [AMP_WIDTH-1:0]      sin_val, cos_val;
   logic [AMP_WIDTH-1:0]      sin_q, cos_q;
   logic [PHASE_WIDTH-1:0]    phase_q;

   // NOTE: datapath and table registers carry no reset; only the valids and
   // the visible outputs do, since nothing downstream looks at data without
   // its valid.
   always_ff @(posedge clk) begin
      // Odd quadrants read the table mirrored; cosine is sine one quadrant on,
      // so its mirror is the opposite one and its sign is q[1] ^ q[0].
      s1_phase    <= p;
      s1_sin_addr <= q[0] ? ~idx : idx;
      s1_cos_addr <= q[0] ? idx : ~idx;
      s1_sin_neg  <= q[1];
      s1_cos_neg  <= q[1] ^ q[0];

      s2_phase    <= s1_phase;
      s2_sin_mag  <= rom[s1_sin_addr];
      s2_cos_mag  <= rom[s1_cos_addr];
      s2_sin_neg  <= s1_sin_neg;
      s2_cos_neg  <= s1_cos_neg;
   end

   always_comb begin
      sin_val = {1'b0, s2_sin_mag};
      cos_val = {1'b0, s2_cos_mag};
      if (s2_sin_neg) sin_val = -sin_val;
      if (s2_cos_neg) cos_val = -cos_val;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
         sin_q     <= '0;
         cos_q     <= '0;
         phase_q   <= '0;
      end else begin
         s1_valid  <= bus.sample_valid_i;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
         // Outputs hold their last sample between pulses.
         if (s2_valid) begin
            sin_q   <= sin_val;
            cos_q   <= cos_val;
            phase_q <= s2_phase;
         end
      end
   end

   assign bus.nco_valid_o = out_valid;
   assign bus.sin_o       = sin_q;
   assign bus.cos_o       = cos_q;
   assign bus.phase_o     = phase_q;
endmodule

// File: tb/tb_cfo_nco.sv
// -----------------------------------------------------------------------------
// tb_cfo_nco
// Self-checking bench for cfo_nco: reset values, a directed vector table for
// DC / quarter-cycle / negative / bursty / phase-clear sequences, a second
// instance with a non-zero FREQ_OFFSET, a mid-stream reset, and a randomized
// run scored against a real-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_cfo_nco;
   localparam int PW  = 32;
   localparam int LAW = 10;
   localparam int AW  = 16;
   localparam logic [PW-1:0] OFS1 = 32'h1000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cfo_nco_if #(.PHASE_WIDTH(PW), .AMP_WIDTH(AW)) bus0 ();
   cfo_nco_if #(.PHASE_WIDTH(PW), .AMP_WIDTH(AW)) bus1 ();

   cfo_nco #(.PHASE_WIDTH(PW), .LUT_ADDR_WIDTH(LAW), .AMP_WIDTH(AW), .FREQ_OFFSET(32'h0))
      u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
   cfo_nco #(.PHASE_WIDTH(PW), .LUT_ADDR_WIDTH(LAW), .AMP_WIDTH(AW), .FREQ_OFFSET(OFS1))
      u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive0(input logic fv, input logic [PW-1:0] fw,
                         input logic sv, input logic clr);
      bus0.freq_valid_i   = fv;
      bus0.freq_word_i    = fw;
      bus0.sample_valid_i = sv;
      bus0.phase_clr_i    = clr;
   endtask

   task automatic drive1(input logic fv, input logic [PW-1:0] fw, input logic sv);
      bus1.freq_valid_i   = fv;
      bus1.freq_word_i    = fw;
      bus1.sample_valid_i = sv;
      bus1.phase_clr_i    = 1'b0;
   endtask

   // Reference: ideal sinusoid sampled at the centre of the 4N-slot bin the
   // phase falls in, rounded half away from zero.
   function automatic int rnd(input real x);
      if (x >= 0.0) return $rtoi(x + 0.5);
      return -$rtoi(-x + 0.5);
   endfunction

   function automatic void ref_cs(input logic [PW-1:0] ph, output int c, output int s);
      int  j;
      real th;
      j  = int'(ph >> (PW - 2 - LAW));
      th = 2.0 * 3.14159265358979323846 * (real'(j) + 0.5) / real'(4 * (1 << LAW));
      c  = rnd(32767.0 * $cos(th));
      s  = rnd(32767.0 * $sin(th));
   endfunction

   typedef struct {
      logic          fv;
      logic [PW-1:0] fw;
      logic          sv;
      logic          clr;
      logic          ev;
      logic [PW-1:0] ep;
      int            ec;
      int            es;
      logic          chk_cs;
   } vec_t;

   function automatic vec_t mk(input logic fv, input logic [PW-1:0] fw, input logic sv,
                               input logic clr, input logic ev, input logic [PW-1:0] ep,
                               input int ec, input int es, input logic chk_cs);
      vec_t v;
      v.fv = fv; v.fw = fw; v.sv = sv; v.clr = clr;
      v.ev = ev; v.ep = ep; v.ec = ec; v.es = es; v.chk_cs = chk_cs;
      return v;
   endfunction

   typedef struct {
      int            due;
      logic [PW-1:0] ph;
   } exp_t;

   vec_t vecs [32];
   exp_t sb [$];
   logic [PW-1:0] got1 [$];

   initial begin
      logic [PW-1:0] m_freq, m_acc, last_ph, exp_ph1 [5];
      int            last_c, last_s, ec, es, cyc;
      logic          fv, sv, clr;
      logic [PW-1:0] fw;
      logic          in1_fv [6];
      logic [PW-1:0] in1_fw [6];
      logic          in1_sv [6];

      // Each row: inputs driven this cycle, then outputs expected at the start
      // of this cycle (i.e. from the row three steps earlier).
      vecs[0]  = mk(0, 32'h0,         1, 0,  0, 32'h0,           0,      0, 1);
      vecs[1]  = mk(0, 32'h0,         1, 0,  0, 32'h0,           0,      0, 1);
      vecs[2]  = mk(0, 32'h0,         1, 0,  0, 32'h0,           0,      0, 1);
      vecs[3]  = mk(1, 32'h4000_0000, 0, 0,  1, 32'h0,       32767,     25, 1);
      vecs[4]  = mk(0, 32'h0,         1, 0,  1, 32'h0,       32767,     25, 1);
      vecs[5]  = mk(0, 32'h0,         1, 0,  1, 32'h0,       32767,     25, 1);
      vecs[6]  = mk(0, 32'h0,         1, 0,  0, 32'h0,       32767,     25, 1);
      vecs[7]  = mk(0, 32'h0,         1, 0,  1, 32'h0,       32767,     25, 1);
      vecs[8]  = mk(1, 32'hC000_0000, 0, 0,  1, 32'h4000_0000,  -25,  32767, 1);
      vecs[9]  = mk(0, 32'h0,         1, 0,  1, 32'h8000_0000, -32767,  -25, 1);
      vecs[10] = mk(0, 32'h0,         1, 0,  1, 32'hC000_0000,    25, -32767, 1);
      vecs[11] = mk(0, 32'h0,         1, 0,  0, 32'hC000_0000,    25, -32767, 1);
      vecs[12] = mk(0, 32'h0,         1, 0,  1, 32'h0,        32767,     25, 1);
      vecs[13] = mk(1, 32'h4000_0000, 0, 0,  1, 32'hC000_0000,    25, -32767, 1);
      vecs[14] = mk(0, 32'h0,         1, 0,  1, 32'h8000_0000, -32767,  -25, 1);
      vecs[15] = mk(0, 32'h0,         0, 0,  1, 32'h4000_0000,  -25,  32767, 1);
      vecs[16] = mk(0, 32'h0,         0, 0,  0, 32'h4000_0000,  -25,  32767, 1);
      vecs[17] = mk(0, 32'h0,         1, 0,  1, 32'h0,        32767,     25, 1);
      vecs[18] = mk(1, 32'h2000_0000, 1, 0,  0, 32'h0,        32767,     25, 1);
      vecs[19] = mk(0, 32'h0,         1, 0,  0, 32'h0,        32767,     25, 1);
      vecs[20] = mk(0, 32'h0,         1, 0,  1, 32'h4000_0000,  -25,  32767, 1);
      vecs[21] = mk(1, 32'h4000_0000, 0, 0,  1, 32'h8000_0000, -32767,  -25, 1);
      vecs[22] = mk(0, 32'h0,         1, 0,  1, 32'hC000_0000,    25, -32767, 1);
      vecs[23] = mk(0, 32'h0,         1, 0,  1, 32'hE000_0000,     0,      0, 0);
      vecs[24] = mk(0, 32'h0,         1, 1,  0, 32'hE000_0000,     0,      0, 0);
      vecs[25] = mk(0, 32'h0,         1, 0,  1, 32'h0,        32767,     25, 1);
      vecs[26] = mk(0, 32'h0,         0, 1,  1, 32'h4000_0000,  -25,  32767, 1);
      vecs[27] = mk(0, 32'h0,         1, 0,  1, 32'h0,        32767,     25, 1);
      vecs[28] = mk(0, 32'h0,         0, 0,  1, 32'h4000_0000,  -25,  32767, 1);
      vecs[29] = mk(0, 32'h0,         0, 0,  0, 32'h4000_0000,  -25,  32767, 1);
      vecs[30] = mk(0, 32'h0,         0, 0,  1, 32'h0,        32767,     25, 1);
      vecs[31] = mk(0, 32'h0,         0, 0,  0, 32'h0,        32767,     25, 1);

      drive0(0, '0, 0, 0);
      drive1(0, '0, 0);

      // ---- Reset values, held for 4 cycles ----
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_valid", bus0.nco_valid_o, 0);
         check("rst_cos",   $signed(bus0.cos_o), 0);
         check("rst_sin",   $signed(bus0.sin_o), 0);
         check("rst_phase", {32'h0, bus0.phase_o}, 0);
      end
      rst = 1'b0;

      // ---- Directed vector table ----
      for (int r = 0; r < 32; r++) begin
         @(negedge clk);
         check($sformatf("vec%0d_valid", r), bus0.nco_valid_o, vecs[r].ev);
         check($sformatf("vec%0d_phase", r), {32'h0, bus0.phase_o}, {32'h0, vecs[r].ep});
         if (vecs[r].chk_cs) begin
            check($sformatf("vec%0d_cos", r), $signed(bus0.cos_o), vecs[r].ec);
            check($sformatf("vec%0d_sin", r), $signed(bus0.sin_o), vecs[r].es);
         end
         drive0(vecs[r].fv, vecs[r].fw, vecs[r].sv, vecs[r].clr);
      end
      drive0(0, '0, 0, 0);

      // ---- FREQ_OFFSET instance: steps by OFS1 out of reset, 2*OFS1 after load ----
      in1_sv = '{1, 1, 0, 1, 1, 1};
      in1_fv = '{0, 0, 1, 0, 0, 0};
      in1_fw = '{32'h0, 32'h0, 32'h1000_0000, 32'h0, 32'h0, 32'h0};
      exp_ph1 = '{32'h0, 32'h1000_0000, 32'h2000_0000, 32'h4000_0000, 32'h6000_0000};
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (bus1.nco_valid_o) got1.push_back(bus1.phase_o);
         if (i < 6) drive1(in1_fv[i], in1_fw[i], in1_sv[i]);
         else       drive1(0, '0, 0);
      end
      check("ofs_count", got1.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < got1.size())
            check($sformatf("ofs_phase%0d", i), {32'h0, got1[i]}, {32'h0, exp_ph1[i]});

      // ---- Mid-stream reset with three samples in flight ----
      @(negedge clk); drive0(0, '0, 1, 0);
      @(negedge clk); drive0(0, '0, 1, 0);
      @(negedge clk); drive0(0, '0, 1, 0); rst = 1'b1;
      @(negedge clk);
      check("mrst_valid", bus0.nco_valid_o, 0);
      check("mrst_phase", {32'h0, bus0.phase_o}, 0);
      rst = 1'b0;
      drive0(0, '0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("mrst_quiet%0d", i), bus0.nco_valid_o, 0);
      end
      drive0(1, 32'h4000_0000, 1, 0);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         drive0(0, '0, 0, 0);
         check($sformatf("mrst_lat%0d", i), bus0.nco_valid_o, (i == 3) ? 1 : 0);
      end
      check("mrst_first_phase", {32'h0, bus0.phase_o}, 0);
      check("mrst_first_cos", $signed(bus0.cos_o), 32767);

      // ---- Randomized run against the reference model ----
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      @(negedge clk); rst = 1'b0;
      m_freq = '0; m_acc = '0; last_ph = '0; last_c = 0; last_s = 0; cyc = 0;
      sb.delete();
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         cyc++;
         if (sb.size() > 0 && sb[0].due == cyc) begin
            ref_cs(sb[0].ph, ec, es);
            check("rnd_valid", bus0.nco_valid_o, 1);
            check("rnd_phase", {32'h0, bus0.phase_o}, {32'h0, sb[0].ph});
            check("rnd_cos", $signed(bus0.cos_o), ec);
            check("rnd_sin", $signed(bus0.sin_o), es);
            last_ph = sb[0].ph; last_c = ec; last_s = es;
            void'(sb.pop_front());
         end else begin
            check("rnd_idle_valid", bus0.nco_valid_o, 0);
            check("rnd_hold_phase", {32'h0, bus0.phase_o}, {32'h0, last_ph});
            check("rnd_hold_cos", $signed(bus0.cos_o), last_c);
            check("rnd_hold_sin", $signed(bus0.sin_o), last_s);
         end
         fv  = ($urandom_range(0, 7) == 0);
         fw  = $urandom;
         sv  = (n < 2990) && ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 15) == 0);
         drive0(fv, fw, sv, clr);
         if (sv) sb.push_back('{due: cyc + 3, ph: (clr ? '0 : m_acc)});
         if (clr)     m_acc = sv ? m_freq : '0;
         else if (sv) m_acc = m_acc + m_freq;
         if (fv) m_freq = fw;
      end
      check("rnd_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
